// File: rtl/cnt_pwm_gen.sv
// PWM generator slaved to an upstream 4-bit down counter, with
// a shadowed duty register and a saturating completed-period counter.
module cnt_pwm_gen #(
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cnt_in,
  input  logic              cnt_valid,
  input  logic [3:0]        duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_pulse,
  output logic [PCNT_W-1:0] period_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_prev_cnt;
  logic              r_prev_valid;
  logic [3:0]        r_duty_act;
  logic [3:0]        r_shadow;
  logic              r_pending;
  logic              r_pwm;
  logic              r_pulse;
  logic [PCNT_W-1:0] r_pcnt;

  logic              w_wrap;
  logic              w_xfer;
  logic [3:0]        w_duty_eff;
  logic              w_pwm_nxt;
  logic              w_pulse_nxt;
  logic [1:0]        w_state_nxt;

  assign w_wrap = cnt_valid && r_prev_valid &&
                  (r_prev_cnt == 4'h0) && (cnt_in == 4'hF);

  assign duty_ready = rst || !r_pending;
  assign w_xfer     = duty_valid && !r_pending;

  // Duty that governs the period starting in this cycle
  always_comb begin
    w_duty_eff = r_duty_act;
    if (w_wrap) begin
      if (w_xfer)
        w_duty_eff = duty_in;
      else if (r_pending)
        w_duty_eff = r_shadow;
    end
  end

  assign w_pwm_nxt = ((r_state == S_RUN) || w_wrap) && cnt_valid &&
                     (cnt_in > (4'hF - w_duty_eff));

  assign w_pulse_nxt = w_wrap && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (cnt_valid) w_state_nxt = S_SYNC;
      S_SYNC: begin
        if (!cnt_valid)  w_state_nxt = S_IDLE;
        else if (w_wrap) w_state_nxt = S_RUN;
      end
      S_RUN:  if (!cnt_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev_cnt   <= 4'h0;
      r_prev_valid <= 1'b0;
      r_duty_act   <= 4'h0;
      r_shadow     <= 4'h0;
      r_pending    <= 1'b0;
      r_pwm        <= 1'b0;
      r_pulse      <= 1'b0;
      r_pcnt       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_cnt   <= cnt_in;
      r_prev_valid <= cnt_valid;
      r_pwm        <= w_pwm_nxt;
      r_pulse      <= w_pulse_nxt;
      r_duty_act   <= w_duty_eff;
      if (w_wrap) begin
        r_pending <= 1'b0;
      end else if (w_xfer) begin
        r_shadow  <= duty_in;
        r_pending <= 1'b1;
      end
      if (w_pulse_nxt && (r_pcnt != '1))
        r_pcnt <= r_pcnt + PCNT_W'(1);
    end
  end

  assign pwm_out      = r_pwm;
  assign period_pulse = r_pulse;
  assign period_count = r_pcnt;

endmodule

// File: tb/tb_cnt_pwm_gen.sv
// Bench for cnt_pwm_gen: vector table, directed period sequences,
// and randomized traffic against a period-level reference model.
`timescale 1ns/1ps
module tb_cnt_pwm_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'h0;
  logic       cnt_valid = 1'b0;
  logic [3:0] duty_in = 4'h0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, pwm_out, period_pulse;
  logic [7:0] period_count;
  logic       duty_ready2, pwm_out2, period_pulse2;
  logic [1:0] period_count2;

  always #5 clk = ~clk;

  cnt_pwm_gen #(.PCNT_W(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .pwm_out(pwm_out),
    .period_pulse(period_pulse), .period_count(period_count));

  cnt_pwm_gen #(.PCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .duty_in(duty_in), .duty_valid(duty_valid),
    .duty_ready(duty_ready2), .pwm_out(pwm_out2),
    .period_pulse(period_pulse2), .period_count(period_count2));

  int n_vec = 0;
  int n_err = 0;
  int highs = 0;
  int pulses = 0;
  int tb_c = 15;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether the counter stream is enabled and
  // whether a full 0->F boundary has been seen since it was enabled.
  int m_prev_cnt = 0, m_prev_valid = 0;
  int m_enabled = 0, m_locked = 0;
  int m_duty = 0, m_shadow = 0, m_pend = 0;
  int m_pc8 = 0, m_pc2 = 0;
  int m_pwm = 0, m_pulse = 0;

  task automatic model_step(input int r, input int cv, input int c,
                            input int dv, input int din);
    int boundary, take, period_duty;
    if (r != 0) begin
      m_prev_cnt = 0; m_prev_valid = 0; m_enabled = 0; m_locked = 0;
      m_duty = 0; m_shadow = 0; m_pend = 0; m_pc8 = 0; m_pc2 = 0;
      m_pwm = 0; m_pulse = 0;
      return;
    end
    boundary = (cv != 0 && m_prev_valid != 0 && m_prev_cnt == 0 && c == 15);
    take = (dv != 0 && m_pend == 0);
    period_duty = m_duty;
    if (boundary != 0)
      period_duty = take ? din : (m_pend ? m_shadow : m_duty);
    // position within the period: F is slot 0, 0 is slot 15
    m_pwm = ((m_locked != 0 || boundary != 0) && cv != 0 &&
             (15 - c) < period_duty) ? 1 : 0;
    m_pulse = (boundary != 0 && m_enabled != 0) ? 1 : 0;
    if (m_pulse != 0) begin
      if (m_pc8 < 255) m_pc8++;
      if (m_pc2 < 3) m_pc2++;
    end
    m_duty = period_duty;
    if (boundary != 0) m_pend = 0;
    else if (take != 0) begin m_shadow = din; m_pend = 1; end
    if (cv == 0) begin m_enabled = 0; m_locked = 0; end
    else if (m_enabled == 0) m_enabled = 1;
    else if (boundary != 0) m_locked = 1;
    m_prev_cnt = c;
    m_prev_valid = cv;
  endtask

  task automatic drive(input logic r, input logic cv, input logic [3:0] c,
                       input logic dv, input logic [3:0] din);
    int exp_ready;
    rst = r; cnt_valid = cv; cnt_in = c; duty_valid = dv; duty_in = din;
    #1;
    exp_ready = (r || m_pend == 0) ? 1 : 0;
    chk("duty_ready", duty_ready, exp_ready);
    model_step(int'(r), int'(cv), int'(c), int'(dv), int'(din));
    @(posedge clk);
    #1;
    chk("pwm_out", pwm_out, m_pwm);
    chk("period_pulse", period_pulse, m_pulse);
    chk("period_count", period_count, m_pc8);
    chk("period_count_w2", period_count2, m_pc2);
    highs += int'(pwm_out);
    pulses += int'(period_pulse);
  endtask

  task automatic tick(input logic dv, input logic [3:0] din);
    drive(1'b0, 1'b1, 4'(tb_c), dv, din);
    tb_c = (tb_c + 15) % 16;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    tb_c = 15;
  endtask

  typedef struct {
    logic       rst;
    logic       cv;
    logic [3:0] cnt;
    logic       e_pwm;
    logic       e_pulse;
    logic [7:0] e_cnt;
    logic       e_ready;
  } vec_t;

  vec_t tv[18];
  int   pc2_exp[5];

  initial begin
    tv[0] = '{rst: 1'b1, cv: 1'b0, cnt: 4'h0,
              e_pwm: 1'b0, e_pulse: 1'b0, e_cnt: 8'd0, e_ready: 1'b1};
    for (int i = 1; i <= 16; i++)
      tv[i] = '{rst: 1'b0, cv: 1'b1, cnt: 4'(16 - i),
                e_pwm: 1'b0, e_pulse: 1'b0, e_cnt: 8'd0, e_ready: 1'b1};
    tv[17] = '{rst: 1'b0, cv: 1'b1, cnt: 4'hF,
               e_pwm: 1'b0, e_pulse: 1'b1, e_cnt: 8'd1, e_ready: 1'b1};
    pc2_exp = '{1, 2, 3, 3, 3};

    @(posedge clk);
    #1;

    // First sync after reset: quiet until the 0->F boundary
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].rst, tv[i].cv, tv[i].cnt, 1'b0, 4'h0);
      chk("tbl_pwm", pwm_out, tv[i].e_pwm);
      chk("tbl_pulse", period_pulse, tv[i].e_pulse);
      chk("tbl_count", period_count, tv[i].e_cnt);
      chk("tbl_ready", duty_ready, tv[i].e_ready);
    end

    // Duty 4 accepted during SYNC, applied from the first wrap
    do_reset();
    tick(1'b1, 4'd4);
    repeat (15) tick(1'b0, 4'h0);
    highs = 0;
    repeat (16) tick(1'b0, 4'h0);
    chk("duty4_highs", highs, 4);

    // Second offer while pending is refused, then accepted after wrap
    highs = 0;
    repeat (7) tick(1'b0, 4'h0);
    tick(1'b1, 4'd8);
    chk("busy_ready", duty_ready, 0);
    tick(1'b1, 4'd12);
    repeat (7) tick(1'b0, 4'h0);
    chk("duty4_again_highs", highs, 4);
    highs = 0;
    tick(1'b0, 4'h0);
    chk("ready_after_wrap", duty_ready, 1);
    tick(1'b1, 4'd12);
    repeat (14) tick(1'b0, 4'h0);
    chk("duty8_highs", highs, 8);
    highs = 0;
    repeat (16) tick(1'b0, 4'h0);
    chk("duty12_highs", highs, 12);

    // Transfer in the wrap cycle applies to that same period
    highs = 0;
    tick(1'b1, 4'd15);
    chk("wrap_xfer_ready", duty_ready, 1);
    repeat (15) tick(1'b0, 4'h0);
    chk("duty15_highs", highs, 15);
    chk("duty15_last_low", pwm_out, 0);

    // Counter disabled at 7, re-enabled: no pulse until a full wrap
    repeat (8) tick(1'b0, 4'h0);
    drive(1'b0, 1'b0, 4'h7, 1'b0, 4'h0);
    chk("drop_pwm", pwm_out, 0);
    tb_c = 6;
    pulses = 0;
    highs = 0;
    repeat (7) tick(1'b0, 4'h0);
    chk("resync_pulses", pulses, 0);
    chk("resync_highs", highs, 0);
    tick(1'b0, 4'h0);
    chk("resync_wrap_pulse", period_pulse, 1);

    // Narrow period counter saturates at 3
    do_reset();
    repeat (16) tick(1'b0, 4'h0);
    for (int p = 0; p < 5; p++) begin
      tick(1'b0, 4'h0);
      chk("pcnt_w2_seq", period_count2, pc2_exp[p]);
      repeat (15) tick(1'b0, 4'h0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic r, cv, dv;
      logic [3:0] c, d;
      r  = ($urandom_range(0, 299) == 0);
      cv = ($urandom_range(0, 39) != 0);
      dv = ($urandom_range(0, 3) == 0);
      d  = 4'($urandom_range(0, 15));
      c  = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(0, 15)) : 4'(tb_c);
      drive(r, cv, c, dv, d);
      if (cv) tb_c = (int'(c) + 15) % 16;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cnt_pwm_gen.md
CNT_PWM_GEN -- requirements
Module: cnt_pwm_gen

Interface
REQ-001 Parameter: PCNT_W, default 8, width of the period counter.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: cnt_in  input  4  count value from the upstream 4-bit down counter (sequence F,E,...,0,F,...).
REQ-005 Port: cnt_valid  input  1  high while the upstream counter is enabled (its set/rstn deasserted).
REQ-006 Port: duty_in  input  4  requested duty, in units of 1/16 period.
REQ-007 Port: duty_valid  input  1  duty_in offered.
REQ-008 Port: duty_ready  output  1  block can accept duty_in this cycle.
REQ-009 Port: pwm_out  output  1  registered PWM output.
REQ-010 Port: period_pulse  output  1  registered one-cycle strobe per completed counter period.
REQ-011 Port: period_count  output  PCNT_W  number of completed periods since reset, saturating.

Function
REQ-012 The block SHALL register prev_cnt <= cnt_in and prev_valid <= cnt_valid every cycle.
REQ-013 wrap SHALL be defined as cnt_valid && prev_valid && prev_cnt==4'h0 && cnt_in==4'hF.
REQ-014 FSM states SHALL be IDLE, SYNC and RUN.
REQ-015 IDLE -> SYNC when cnt_valid=1; SYNC -> RUN on wrap; SYNC or RUN -> IDLE when cnt_valid=0, which takes priority over wrap.
REQ-016 Duty handshake: transfer occurs when duty_valid && duty_ready; duty_ready = !pending.
REQ-017 A transfer SHALL load shadow <= duty_in and set pending=1, unless wrap occurs in the same cycle.
REQ-018 Transfer in a wrap cycle: duty_in goes directly to duty_act, pending stays 0.
REQ-019 On wrap with pending=1: duty_act <= shadow and pending <= 0.
REQ-020 duty_eff SHALL equal the value duty_act holds after the wrap-cycle update (new value in a wrap cycle, else duty_act).
REQ-021 pwm_out <= (state==RUN || wrap) && cnt_valid && (cnt_in > 15 - duty_eff): one-cycle latency from cnt_in.
REQ-022 Resulting duty: duty 0 gives pwm_out always 0; duty N gives N high cycles out of 16.
REQ-023 period_pulse <= wrap && state!=IDLE; the SYNC -> RUN wrap also pulses.
REQ-024 period_count increments on each period_pulse event and saturates at all-ones (no wrap-around).
REQ-025 On transition to IDLE, pwm_out and period_pulse go to 0 next cycle.
REQ-026 duty_act, shadow, pending and period_count are retained across IDLE.
REQ-027 cnt_in SHALL be ignored (no wrap, no pwm) while cnt_valid=0.

Reset
REQ-028 While rst=1, state=IDLE and prev_cnt=0.
REQ-029 While rst=1, prev_valid=0, duty_act=0, shadow=0 and pending=0.
REQ-030 While rst=1, pwm_out=0, period_pulse=0, period_count=0 and duty_ready=1.
REQ-031 rst asserted mid-period SHALL override all other events in that cycle.
REQ-032 After rst, the block SHALL resynchronise through SYNC; no wrap is seen until prev_valid is rebuilt.

Verification
REQ-033 Reset then cnt_valid=1 driving F..0 -> pwm_out=0 and period_pulse=0 until cnt_in goes 0 -> F; then period_pulse=1 one cycle and period_count=1.
REQ-034 duty_in=4 accepted in SYNC, one full period in RUN -> pwm_out high for exactly the 4 cycles after cnt_in F,E,D,C; low for the other 12.
REQ-035 duty_in=12 offered mid-period with pending already 1 -> duty_ready=0 and the value is not taken; after the next wrap duty_ready=1 and duty_in=12 is accepted.
REQ-036 Transfer of duty_in=15 in the exact wrap cycle -> duty applied to that period (15 high cycles, pwm low only after cnt_in=0); pending stays 0.
REQ-037 cnt_valid dropped mid-period at cnt_in=7 -> pwm_out=0 next cycle, state IDLE; re-enable -> no pulse until a full 0 -> F wrap occurs.
REQ-038 PCNT_W=2, run 5 periods -> period_count reads 1,2,3,3,3.
